// File: rtl/cpu_pkg.sv
// Shared CPU parameters: data width, register address width, register count,
// the x0 address and the register address type.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 2 ** AW;

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : cpu_pkg

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the architectural register file.
// Ports:
//   clk, reset (async active-low)
//   sb_set/sb_addr     : decode marks a destination pending
//   wb_write/wb_addr   : write-back clears the destination's pending bit
//   rd_req/rs1/rs2     : current read request
//   busy_mask          : registered pending vector, bit i = xi pending
//   rd_stall           : comb, request refused because a source is unresolved
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             wb_write,
    input  logic [AW-1:0]    wb_addr,
    input  logic             rd_req,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [NREGS-1:0] busy_mask,
    output logic             rd_stall
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rs1_resolved_c;
    logic             rs2_resolved_c;

    // Clear on write-back first so a same-address set from the younger
    // issuing instruction wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_write && (wb_addr != REG_ZERO)) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (sb_set && (sb_addr != REG_ZERO)) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A source is usable if x0, not pending, or arriving on write-back now.
    // Uses pre-edge busy state, so a same-cycle sb_set never stalls its reads.
    assign rs1_resolved_c = (rs1_addr == REG_ZERO) || !busy_q[rs1_addr]
                            || (wb_write && (wb_addr == rs1_addr));
    assign rs2_resolved_c = (rs2_addr == REG_ZERO) || !busy_q[rs2_addr]
                            || (wb_write && (wb_addr == rs2_addr));

    assign rd_stall  = rd_req && !(rs1_resolved_c && rs2_resolved_c);
    assign busy_mask = busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Architectural register file with pending-write scoreboard.
// Ports:
//   clk, reset (async active-low)
//   wb_data/wb_addr/wb_write : write-back feedback bus
//   rd_req/rs1_addr/rs2_addr : decode read request
//   rd_stall (comb), rd_valid/rs1_data/rs2_data (registered, latency 1)
//   sb_set/sb_addr           : mark destination pending at issue
//   busy_mask                : scoreboard state
module reg_file_sb
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  wb_data,
    input  logic [AW-1:0]    wb_addr,
    input  logic             wb_write,
    input  logic             rd_req,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic             rd_stall,
    output logic             rd_valid,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    output logic [NREGS-1:0] busy_mask
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            rd_valid_q, rd_valid_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] rs1_val_c, rs2_val_c;
    logic            rd_accept_c;

    reg_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .wb_write  (wb_write),
        .wb_addr   (wb_addr),
        .rd_req    (rd_req),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .busy_mask (busy_mask),
        .rd_stall  (rd_stall)
    );

    // Write port; x0 stays zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_write && (wb_addr != REG_ZERO)) begin
            regs_d[wb_addr] = wb_data;
        end
        regs_d[REG_ZERO] = '0;
    end

    // Write-first bypass muxes.
    always_comb begin
        rs1_val_c = regs_q[rs1_addr];
        rs2_val_c = regs_q[rs2_addr];
        if (wb_write && (wb_addr == rs1_addr)) begin
            rs1_val_c = wb_data;
        end
        if (wb_write && (wb_addr == rs2_addr)) begin
            rs2_val_c = wb_data;
        end
        if (rs1_addr == REG_ZERO) begin
            rs1_val_c = '0;
        end
        if (rs2_addr == REG_ZERO) begin
            rs2_val_c = '0;
        end
    end

    // Read output registers: data holds when nothing is accepted.
    assign rd_accept_c = rd_req && !rd_stall;

    always_comb begin
        rd_valid_d = rd_accept_c;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (rd_accept_c) begin
            rs1_data_d = rs1_val_c;
            rs2_data_d = rs2_val_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            rd_valid_q <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_valid_q <= rd_valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_write;
    logic        rd_req;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_stall;
    logic        rd_valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [31:0] busy_mask;

    int errors = 0;
    int checks = 0;

    // Behavioural model: architectural state and expected registered outputs.
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        e_valid;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;

    reg_file_sb dut (
        .clk       (clk),
        .reset     (reset),
        .wb_data   (wb_data),
        .wb_addr   (wb_addr),
        .wb_write  (wb_write),
        .rd_req    (rd_req),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_stall  (rd_stall),
        .rd_valid  (rd_valid),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register value a source sees this cycle: x0 is zero, write-back data wins.
    function automatic logic [31:0] m_value(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_write && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_ready(input logic [4:0] a);
        return (a == 5'd0) || !m_busy[a] || (wb_write && wb_addr == a);
    endfunction

    function automatic logic m_stall();
        return rd_req && !(m_ready(rs1_addr) && m_ready(rs2_addr));
    endfunction

    // Compare process: check, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_busy  = 32'd0;
            e_valid = 1'b0;
            e_rs1   = 32'd0;
            e_rs2   = 32'd0;
            chk("rst_valid", {31'd0, rd_valid}, 32'd0);
            chk("rst_busy", busy_mask, 32'd0);
            chk("rst_rs1", rs1_data, 32'd0);
            chk("rst_rs2", rs2_data, 32'd0);
        end else begin
            chk("m_valid", {31'd0, rd_valid}, {31'd0, e_valid});
            chk("m_rs1", rs1_data, e_rs1);
            chk("m_rs2", rs2_data, e_rs2);
            chk("m_busy", busy_mask, m_busy);
            chk("m_stall", {31'd0, rd_stall}, {31'd0, m_stall()});
            e_valid = rd_req && !m_stall();
            if (e_valid) begin
                e_rs1 = m_value(rs1_addr);
                e_rs2 = m_value(rs2_addr);
            end
            if (wb_write && wb_addr != 5'd0) begin
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_write = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        rd_req = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        sb_set = 1'b0; sb_addr = 5'd0;
    endtask

    initial begin
        logic held;
        reset = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 32'd0; e_valid = 1'b0; e_rs1 = 32'd0; e_rs2 = 32'd0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // 1: reset in the middle of a read drops it; storage cleared.
        wb_write = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5A5_5A5A;
        sb_set = 1'b1; sb_addr = 5'd6;
        tick();
        idle();
        rd_req = 1'b1; rs1_addr = 5'd5;
        #2 reset = 1'b0;
        #1;
        chk("t1_valid_in_reset", {31'd0, rd_valid}, 32'd0);
        chk("t1_busy_in_reset", busy_mask, 32'd0);
        tick();
        reset = 1'b1;
        idle();
        tick();
        chk("t1_no_valid_after", {31'd0, rd_valid}, 32'd0);
        rd_req = 1'b1; rs1_addr = 5'd5;
        tick();
        chk("t1_valid", {31'd0, rd_valid}, 32'd1);
        chk("t1_x5_zero", rs1_data, 32'd0);

        // 2: write then read.
        idle();
        wb_write = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        tick();
        idle();
        rd_req = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd0;
        tick();
        chk("t2_valid", {31'd0, rd_valid}, 32'd1);
        chk("t2_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("t2_rs2", rs2_data, 32'd0);

        // 3: same-cycle bypass to both ports.
        idle();
        wb_write = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
        rd_req = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd7;
        tick();
        chk("t3_rs1", rs1_data, 32'h0000_1234);
        chk("t3_rs2", rs2_data, 32'h0000_1234);

        // 6: x0 is never busy and never written.
        idle();
        sb_set = 1'b1; sb_addr = 5'd0;
        wb_write = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        rd_req = 1'b1;
        #2 chk("t6_stall", {31'd0, rd_stall}, 32'd0);
        #1;
        tick();
        chk("t6_busy", busy_mask, 32'd0);
        chk("t6_valid", {31'd0, rd_valid}, 32'd1);
        chk("t6_rs1", rs1_data, 32'd0);
        chk("t6_rs2", rs2_data, 32'd0);

        // 4: stall until write-back resolves the pending source.
        idle();
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle();
        rd_req = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd9;
        #2 chk("t4_stall", {31'd0, rd_stall}, 32'd1);
        #1;
        tick();
        chk("t4_no_valid", {31'd0, rd_valid}, 32'd0);
        wb_write = 1'b1; wb_addr = 5'd9; wb_data = 32'd55;
        #2 chk("t4_unstall", {31'd0, rd_stall}, 32'd0);
        #1;
        tick();
        chk("t4_valid", {31'd0, rd_valid}, 32'd1);
        chk("t4_rs2", rs2_data, 32'd55);
        chk("t4_busy9", {31'd0, busy_mask[9]}, 32'd0);

        // 5: same-address set and clear: set wins, data still commits.
        idle();
        sb_set = 1'b1; sb_addr = 5'd4;
        wb_write = 1'b1; wb_addr = 5'd4; wb_data = 32'd1;
        tick();
        idle();
        chk("t5_busy4", {31'd0, busy_mask[4]}, 32'd1);
        chk("t5_model_x4", m_regs[4], 32'd1);

        // Random traffic on a small address window to provoke hazards.
        held = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!held) begin
                rd_req   = ($urandom_range(0, 2) != 0);
                rs1_addr = 5'($urandom_range(0, 7));
                rs2_addr = 5'($urandom_range(0, 7));
            end
            wb_write = ($urandom_range(0, 1) == 1);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            sb_set   = ($urandom_range(0, 3) == 0);
            sb_addr  = 5'($urandom_range(0, 7));
            held     = m_stall();
            tick();
        end
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file_sb
